// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter, instruction register and a two-state
// IDLE/REQ memory handshake. Define FETCH_TIMEOUT_EN to abort fetches after 15 unacked cycles.
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_rst,
    input  logic        pc_write,
    input  logic        pc_sel,
    input  logic        br_sel,
    input  logic        ir_load,
    output logic        im_req,
    output logic [15:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [15:0] pc,
    output logic [31:0] ir,
    output logic [3:0]  opcode,
    output logic [3:0]  mm,
    output logic        fetch_busy,
    output logic        fetch_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        addr_en;
    logic        ir_en;
    logic [31:0] ir_d;
    logic [15:0] pc_d;
    logic        err_set;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0]  tmo_cnt;
    logic        tmo_hit;

    // Counter holds (REQ cycles elapsed - 1); 14 marks the 15th unacked cycle.
    assign tmo_hit = (tmo_cnt == 4'd14);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= 4'd0;
        end else if (state_q == IDLE) begin
            tmo_cnt <= 4'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
        end
    end
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        addr_en = 1'b0;
        ir_en   = 1'b0;
        ir_d    = im_rdata;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (ir_load) begin
                    state_d = REQ;
                    addr_en = 1'b1;
                end
            end
            REQ: begin
                if (im_ack) begin
                    state_d = IDLE;
                    ir_en   = 1'b1;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = IDLE;
                    ir_en   = 1'b1;
                    ir_d    = 32'h0;
                    err_set = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Sign-extending a 16-bit offset into a 16-bit sum is a plain modulo-2^16 add.
    always_comb begin
        pc_d = pc;
        if (pc_rst) begin
            pc_d = 16'h0000;
        end else if (pc_write) begin
            if (!pc_sel)     pc_d = pc + 16'd1;
            else if (br_sel) pc_d = ir[15:0];
            else             pc_d = pc + ir[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc      <= 16'h0000;
            ir      <= 32'h0;
            im_addr <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values,
            // which lets im_addr capture the old pc while pc updates in the same edge.
            state_q <= state_d;
            pc      <= pc_d;
            if (ir_en)   ir      <= ir_d;
            if (addr_en) im_addr <= pc;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          fetch_err <= 1'b0;
        else if (err_set) fetch_err <= 1'b1;
    end
`else
    assign fetch_err = 1'b0;
    logic unused_err;
    assign unused_err = err_set;
`endif

    assign im_req     = (state_q == REQ);
    assign fetch_busy = (state_q == REQ);
    assign opcode     = ir[31:28];
    assign mm         = ir[27:24];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stimulus, all compared against a transaction-level model of pc/ir/fetch.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_rst, pc_write, pc_sel, br_sel, ir_load;
    logic        im_req, im_ack;
    logic [15:0] im_addr, pc;
    logic [31:0] im_rdata, ir;
    logic [3:0]  opcode, mm;
    logic        fetch_busy, fetch_err;

    int errors = 0;
    int checks = 0;

    // Reference model: a program counter, an instruction register, and at most
    // one outstanding fetch described by its address and age in cycles.
    int          m_pc;
    logic [31:0] m_ir;
    bit          m_pending;
    int          m_addr;
    int          m_age;
    bit          m_err;

    fetch_unit dut (
        .clk(clk), .rst(rst), .pc_rst(pc_rst), .pc_write(pc_write),
        .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load),
        .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
        .pc(pc), .ir(ir), .opcode(opcode), .mm(mm),
        .fetch_busy(fetch_busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 32'h0; m_pending = 0; m_addr = 0; m_age = 0; m_err = 0;
    endtask

    task automatic model_step();
        int next_pc;
        next_pc = m_pc;
        if (pc_rst)
            next_pc = 0;
        else if (pc_write && !pc_sel)
            next_pc = (m_pc + 1) % 65536;
        else if (pc_write && br_sel)
            next_pc = int'(m_ir[15:0]);
        else if (pc_write)
            next_pc = (m_pc + int'($signed(m_ir[15:0])) + 65536) % 65536;

        if (!m_pending) begin
            if (ir_load) begin
                m_pending = 1; m_addr = m_pc; m_age = 0;
            end
        end else if (im_ack) begin
            m_ir = im_rdata; m_pending = 0;
        end else begin
            m_age++;
`ifdef FETCH_TIMEOUT_EN
            if (m_age == 15) begin
                m_ir = 32'h0; m_pending = 0; m_err = 1;
            end
`endif
        end
        m_pc = next_pc;
    endtask

    task automatic compare_all(input string where);
        check({where, ":pc"},   {16'h0, pc},        m_pc);
        check({where, ":ir"},   ir,                 m_ir);
        check({where, ":op"},   {28'h0, opcode},    {28'h0, m_ir[31:28]});
        check({where, ":mm"},   {28'h0, mm},        {28'h0, m_ir[27:24]});
        check({where, ":req"},  {31'h0, im_req},    {31'h0, m_pending});
        check({where, ":busy"}, {31'h0, fetch_busy}, {31'h0, m_pending});
        check({where, ":addr"}, {16'h0, im_addr},   m_addr);
        check({where, ":err"},  {31'h0, fetch_err}, {31'h0, m_err});
    endtask

    task automatic idle_inputs();
        pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0; ir_load = 0;
        im_ack = 0; im_rdata = 32'h0;
    endtask

    task automatic cycle(input string where);
        @(posedge clk);
        model_step();
        #1;
        compare_all(where);
    endtask

    task automatic do_reset(input string where);
        rst = 1;
        model_reset();
        #1;
        compare_all(where);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic load_ir(input logic [31:0] data);
        idle_inputs();
        ir_load = 1;
        cycle("ld_req");
        idle_inputs();
        im_ack = 1; im_rdata = data;
        cycle("ld_ack");
        idle_inputs();
    endtask

    task automatic set_pc(input logic [15:0] v);
        load_ir({16'h0, v});
        pc_write = 1; pc_sel = 1; br_sel = 1;
        cycle("setpc");
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        model_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        rst = 0;

        // Zero-wait fetch with a concurrent pc increment.
        set_pc(16'h0005);
        ir_load = 1; pc_write = 1;
        cycle("zw_req");
        check("zw_addr", {16'h0, im_addr}, 32'h5);
        check("zw_pc", {16'h0, pc}, 32'h6);
        idle_inputs();
        im_ack = 1; im_rdata = 32'h8100_0003;
        cycle("zw_ack");
        check("zw_ir", ir, 32'h8100_0003);
        check("zw_opcode", {28'h0, opcode}, 32'h8);
        check("zw_mm", {28'h0, mm}, 32'h1);
        idle_inputs();

        // Three wait states; a second ir_load mid-fetch must not disturb it.
        set_pc(16'h0020);
        ir_load = 1;
        cycle("ws_req");
        idle_inputs();
        pc_write = 1;
        for (int i = 0; i < 3; i++) begin
            ir_load = (i == 1);
            cycle("ws_wait");
            check("ws_addr", {16'h0, im_addr}, 32'h20);
            check("ws_busy", {31'h0, fetch_busy}, 32'h1);
        end
        idle_inputs();
        im_ack = 1; im_rdata = 32'h4200_0040;
        cycle("ws_ack");
        check("ws_done", {31'h0, fetch_busy}, 32'h0);
        idle_inputs();

        // Absolute branch from ir = 32'h4200_0040.
        pc_write = 1; pc_sel = 1; br_sel = 1;
        cycle("abs");
        check("abs_pc", {16'h0, pc}, 32'h40);
        idle_inputs();

        // Relative branch backwards by 4, then wrap of pc+1 at the top of memory.
        set_pc(16'h0010);
        load_ir(32'h0000_FFFC);
        pc_write = 1; pc_sel = 1; br_sel = 0;
        cycle("rel");
        check("rel_pc", {16'h0, pc}, 32'h000C);
        idle_inputs();
        set_pc(16'hFFFF);
        pc_write = 1;
        cycle("wrap");
        check("wrap_pc", {16'h0, pc}, 32'h0);
        idle_inputs();

        // ack while idle is ignored.
        im_ack = 1; im_rdata = 32'hDEAD_BEEF;
        cycle("idle_ack");
        idle_inputs();

        // Reset mid-fetch, late ack afterwards.
        set_pc(16'h0033);
        ir_load = 1;
        cycle("rm_req");
        idle_inputs();
        #2;
        do_reset("rm_rst");
        check("rm_req0", {31'h0, im_req}, 32'h0);
        im_ack = 1; im_rdata = 32'h1234_5678;
        cycle("rm_late");
        check("rm_ir0", ir, 32'h0);
        idle_inputs();

`ifdef FETCH_TIMEOUT_EN
        // Fetch that is never acked.
        load_ir(32'h7700_0001);
        ir_load = 1;
        cycle("to_req");
        idle_inputs();
        for (int i = 0; i < 16; i++) cycle("to_wait");
        check("to_err", {31'h0, fetch_err}, 32'h1);
        check("to_op", {28'h0, opcode}, 32'h0);
        do_reset("to_rst");
`endif

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            pc_rst   = ($urandom_range(15) == 0);
            pc_write = $urandom_range(1);
            pc_sel   = $urandom_range(1);
            br_sel   = $urandom_range(1);
            ir_load  = $urandom_range(1);
            im_ack   = ($urandom_range(2) == 0);
            im_rdata = $urandom;
            if ($urandom_range(99) == 0) begin
                #2;
                do_reset("rnd_rst");
            end else begin
                cycle("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
